// File: rtl/moving_average_ctrl_if.sv
// Configuration, sample and datapath-control signals shared by the moving-average
// sequencing controller (slave) and whoever configures and feeds it (master).
interface moving_average_ctrl_if #(
    parameter int SIZE_WINDOW = 7
);
    logic                   cfg_valid;
    logic [SIZE_WINDOW-1:0] cfg_window;
    logic                   cfg_ready;
    logic                   cfg_error;
    logic                   sample_valid;
    logic [SIZE_WINDOW-1:0] avg_window;
    logic                   avg_clear;
    logic                   avg_enable;
    logic                   out_valid;
    logic                   busy;

    modport master (
        output cfg_valid, cfg_window, sample_valid,
        input  cfg_ready, cfg_error, avg_window, avg_clear, avg_enable, out_valid, busy
    );

    modport slave (
        input  cfg_valid, cfg_window, sample_valid,
        output cfg_ready, cfg_error, avg_window, avg_clear, avg_enable, out_valid, busy
    );
endinterface

// File: rtl/moving_average_ctrl.sv
// Sequencing controller for the moving-average datapath: validates window changes,
// flushes the history, gates sample enables and holds off out_valid until primed.
module moving_average_ctrl #(
    parameter int SIZE_WINDOW     = 7,
    parameter int SIZE_MAX_WINDOW = 64,
    parameter int PIPE_LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    moving_average_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int FLUSH_W = (SIZE_MAX_WINDOW > 1) ? $clog2(SIZE_MAX_WINDOW) : 1;
    localparam int FILL_W  = $clog2(SIZE_MAX_WINDOW + PIPE_LATENCY + 1);

    localparam logic [FLUSH_W-1:0]     FLUSH_LAST = FLUSH_W'(SIZE_MAX_WINDOW - 1);
    localparam logic [FLUSH_W-1:0]     FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [FILL_W-1:0]      FILL_ONE   = FILL_W'(1);
    localparam logic [FILL_W-1:0]      LAT_M1     = FILL_W'(PIPE_LATENCY - 1);
    localparam logic [SIZE_WINDOW-1:0] WIN_ONE    = SIZE_WINDOW'(1);
    localparam logic [SIZE_WINDOW-1:0] WIN_MAX    = SIZE_WINDOW'(SIZE_MAX_WINDOW);

    logic [1:0]         state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [FILL_W-1:0]  fill_cnt;
    logic [FILL_W-1:0]  fill_target;
    logic               accept;
    logic               legal;
    logic               legal_accept;

    always_comb begin
        bus.cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
        bus.busy      = (state == ST_FLUSH) || (state == ST_FILL);
        accept        = bus.cfg_valid && bus.cfg_ready;
        // Power of two: exactly one bit set, so clearing the lowest set bit leaves zero.
        legal         = (bus.cfg_window != '0)
                     && ((bus.cfg_window & (bus.cfg_window - WIN_ONE)) == '0)
                     && (bus.cfg_window <= WIN_MAX);
        legal_accept  = accept && legal;
        // A sample coinciding with an accepted reconfiguration belongs to neither window.
        bus.avg_enable = bus.sample_valid
                      && ((state == ST_FILL) || (state == ST_RUN))
                      && !legal_accept;
        fill_target   = FILL_W'(bus.avg_window) + LAT_M1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            fill_cnt       <= '0;
            bus.avg_window <= WIN_ONE;
            bus.avg_clear  <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.cfg_error  <= 1'b0;
        end else begin
            bus.cfg_error <= accept && !legal;

            if (legal_accept) begin
                state          <= ST_FLUSH;
                flush_cnt      <= '0;
                bus.avg_window <= bus.cfg_window;
                bus.avg_clear  <= 1'b1;
                bus.out_valid  <= 1'b0;
            end else begin
                case (state)
                    ST_FLUSH: begin
                        bus.out_valid <= 1'b0;
                        if (flush_cnt == FLUSH_LAST) begin
                            state         <= ST_FILL;
                            fill_cnt      <= '0;
                            bus.avg_clear <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + FLUSH_ONE;
                        end
                    end
                    ST_FILL: begin
                        bus.out_valid <= 1'b0;
                        if (bus.avg_enable) begin
                            fill_cnt <= fill_cnt + FILL_ONE;
                            if (fill_cnt == fill_target) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        bus.out_valid <= bus.avg_enable;
                    end
                    default: begin
                        bus.out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_moving_average_ctrl.sv
// Scoreboard bench for moving_average_ctrl: a behavioural model predicts every
// cycle's outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_moving_average_ctrl;
    localparam int SW   = 7;
    localparam int MAXW = 64;
    localparam int LAT  = 4;

    typedef enum int { M_IDLE, M_FLUSH, M_FILL, M_RUN } mode_t;

    typedef struct {
        logic          ready;
        logic          busy;
        logic          clear;
        logic          enable;
        logic          ov;
        logic          err;
        logic [SW-1:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    moving_average_ctrl_if #(.SIZE_WINDOW(SW)) bus ();

    moving_average_ctrl #(
        .SIZE_WINDOW    (SW),
        .SIZE_MAX_WINDOW(MAXW),
        .PIPE_LATENCY   (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the spec's rules as remaining-cycle / remaining-sample budgets.
    mode_t         m_mode;
    int            m_win;
    int            m_flush_left;
    int            m_fill_left;
    logic          m_ov;
    logic          m_err;
    bit            m_took_4;

    function automatic bit is_legal(input logic [SW-1:0] w);
        for (int k = 0; (1 << k) <= MAXW; k++) begin
            if (int'(w) == (1 << k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_win        = 1;
        m_flush_left = 0;
        m_fill_left  = 0;
        m_ov         = 1'b0;
        m_err        = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int want);
        if (act != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, want);
        end
    endtask

    // Apply one cycle of inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic rst_v, input logic cv, input logic [SW-1:0] cw,
                        input logic sv);
        exp_t e;
        bit   ready, accept, legal_acc, en;
        @(posedge clk);
        #1;
        reset            = rst_v;
        bus.cfg_valid    = cv;
        bus.cfg_window   = cw;
        bus.sample_valid = sv;
        if (!rst_v) model_reset();

        ready     = (m_mode == M_IDLE) || (m_mode == M_RUN);
        accept    = rst_v && cv && ready;
        legal_acc = accept && is_legal(cw);
        en        = rst_v && sv && ((m_mode == M_FILL) || (m_mode == M_RUN)) && !legal_acc;

        e.ready  = ready;
        e.busy   = (m_mode == M_FLUSH) || (m_mode == M_FILL);
        e.clear  = (m_mode == M_FLUSH);
        e.enable = en;
        e.ov     = m_ov;
        e.err    = m_err;
        e.win    = SW'(m_win);
        exp_q.push_back(e);

        if (rst_v) begin
            m_err = accept && !legal_acc;
            if (legal_acc) begin
                m_mode       = M_FLUSH;
                m_flush_left = MAXW;
                m_win        = int'(cw);
                m_ov         = 1'b0;
                if (cw == SW'(4)) m_took_4 = 1'b1;
            end else begin
                case (m_mode)
                    M_FLUSH: begin
                        m_ov = 1'b0;
                        m_flush_left--;
                        if (m_flush_left == 0) begin
                            m_mode      = M_FILL;
                            m_fill_left = m_win + LAT;
                        end
                    end
                    M_FILL: begin
                        m_ov = 1'b0;
                        if (en) begin
                            m_fill_left--;
                            if (m_fill_left == 0) m_mode = M_RUN;
                        end
                    end
                    M_RUN:   m_ov = en;
                    default: m_ov = 1'b0;
                endcase
            end
        end
    endtask

    task automatic run(input int n, input logic sv);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, sv);
    endtask

    // Monitor: compare every predicted cycle, half a clock after the driving edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                check("cfg_ready",  int'(bus.cfg_ready),  int'(e.ready));
                check("busy",       int'(bus.busy),       int'(e.busy));
                check("avg_clear",  int'(bus.avg_clear),  int'(e.clear));
                check("avg_enable", int'(bus.avg_enable), int'(e.enable));
                check("out_valid",  int'(bus.out_valid),  int'(e.ov));
                check("cfg_error",  int'(bus.cfg_error),  int'(e.err));
                check("avg_window", int'(bus.avg_window), int'(e.win));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_window   = '0;
        bus.sample_valid = 1'b0;
        m_took_4         = 1'b0;
        model_reset();

        // Reset state, then samples ignored in IDLE.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
        run(4, 1'b1);

        // Window 8 with continuous samples: 64 flush cycles, 12 primed samples, then valid.
        step(1'b1, 1'b1, SW'(8), 1'b1);
        run(MAXW + 8 + LAT + 8, 1'b1);

        // Illegal windows in RUN: one-cycle error pulse each, nothing else disturbed.
        step(1'b1, 1'b1, SW'(0), 1'b1);
        run(3, 1'b1);
        step(1'b1, 1'b1, SW'(3), 1'b1);
        run(3, 1'b1);
        step(1'b1, 1'b1, SW'(96), 1'b1);
        run(3, 1'b1);

        // Request held through FLUSH/FILL is only taken once RUN is reached.
        step(1'b1, 1'b1, SW'(16), 1'b1);
        m_took_4 = 1'b0;
        for (int i = 0; i < 400 && !m_took_4; i++) step(1'b1, 1'b1, SW'(4), 1'b1);
        vectors++;
        check("held_cfg_accept", int'(m_took_4), 1);
        run(MAXW + 4 + LAT + 4, 1'b1);

        // Window 2 with gapped samples through FILL and RUN.
        step(1'b1, 1'b1, SW'(2), 1'b1);
        for (int i = 0; i < MAXW + 30; i++) step(1'b1, 1'b0, '0, logic'(i % 2));

        // Legal accept coinciding with a sample in RUN drops that sample.
        step(1'b1, 1'b1, SW'(8), 1'b1);
        run(MAXW + 5, 1'b1);

        // Asynchronous reset in the middle of FILL, then samples ignored in IDLE.
        step(1'b0, 1'b0, '0, 1'b1);
        run(6, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic          cv;
            logic [SW-1:0] cw;
            logic          sv;
            cv = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) cw = SW'($urandom_range(0, 127));
            else                           cw = SW'(1 << $urandom_range(0, 6));
            sv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 999) == 0) step(1'b0, cv, cw, sv);
            else                             step(1'b1, cv, cw, sv);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/moving_average_ctrl.md
Name: moving_average_ctrl

Overview:
Sequencing controller for the moving-average datapath (shift register, running sum, power-of-two shift). It accepts window-size reconfiguration requests over a valid/ready handshake and validates them. It flushes the datapath history, gates the datapath sample enable, and suppresses output-valid until the new window is fully primed. It sits between the configuration/register interface and the datapath, and owns the datapath's window, clear and enable inputs.

Parameters:
SIZE_WINDOW, 7, width of window fields; legal windows are 1..2^(SIZE_WINDOW-1).
SIZE_MAX_WINDOW, 64, depth of the datapath shift register; also the flush length in cycles; must be a power of two.
PIPE_LATENCY, 4, datapath latency in enabled samples from input to settled output.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  window reconfiguration request
cfg_window  in  SIZE_WINDOW  requested window size
cfg_ready  out  1  controller can accept a request
cfg_error  out  1  one-cycle pulse: request rejected as illegal
sample_valid  in  1  new input sample present this cycle
avg_window  out  SIZE_WINDOW  registered window driven to the datapath
avg_clear  out  1  synchronous clear request to the datapath (sum, history, output)
avg_enable  out  1  datapath shift/accumulate enable
out_valid  out  1  datapath output is a valid average
busy  out  1  flush or priming in progress

Behaviour:
- Reset is asynchronous and active-low. On reset: state=IDLE, avg_window=1, avg_clear=0, out_valid=0, cfg_error=0, flush/fill counters=0.
- Reset outputs follow from IDLE: cfg_ready=1, busy=0, avg_enable=0.
- Reset asserted mid-operation returns to IDLE immediately, from any state.
- States are IDLE, FLUSH, FILL and RUN.
- cfg_ready=1 in IDLE and RUN; 0 in FLUSH and FILL.
- busy=1 exactly in FLUSH and FILL.
- Accept condition: cfg_valid & cfg_ready.
- Legal window: power of two with 1 <= cfg_window <= SIZE_MAX_WINDOW. 0, non-powers-of-two and oversize values are illegal.
- Illegal accept: cfg_error=1 for exactly the next cycle. State, avg_window and out_valid are unchanged; RUN keeps running.
- Legal accept: next cycle avg_window<=cfg_window, state<=FLUSH, flush counter<=0, out_valid<=0.
- A legal accept re-flushes even when cfg_window equals the current avg_window.
- FLUSH:
  - avg_clear=1 and avg_enable=0 for exactly SIZE_MAX_WINDOW cycles; then state<=FILL with fill counter=0.
  - avg_clear is registered; it is high exactly in FLUSH cycles.
- avg_enable (combinational) = sample_valid & (state==FILL | state==RUN) & ~(legal accept this cycle).
- A sample arriving in the same cycle as an accepted reconfiguration is dropped.
- FILL:
  - The fill counter increments on each avg_enable.
  - When avg_enable is high and the counter equals avg_window+PIPE_LATENCY-1: state<=RUN.
  - out_valid stays 0 throughout FILL, including for the last fill sample.
  - The fill counter is sized to hold SIZE_MAX_WINDOW+PIPE_LATENCY without wrap.
- RUN: out_valid <= avg_enable, registered one cycle after each enabled sample. No valid is emitted when no sample is present.
- IDLE: samples are ignored and out_valid=0. IDLE is left only by a legal accept.
- Windows are applied only from RUN/IDLE. A cfg_valid held during FLUSH/FILL waits, not accepted, until RUN.

Test Plan:
- Reset, then cfg_window=8 with sample_valid=1 continuously. Required: cfg_error=0; avg_clear high exactly 64 cycles; then 8+4=12 enabled samples with out_valid=0; out_valid=1 from the following cycle onward; avg_window=8.
- Illegal requests cfg_window=0, 3, 96 in RUN. Required: each produces a one-cycle cfg_error; out_valid and avg_window=8 are unaffected; cfg_ready stays 1.
- cfg_valid held high with window=4 during FLUSH. Required: cfg_ready=0 and no accept until RUN is reached; then a second flush of 64 cycles with avg_window=4.
- Gapped samples in FILL with window=2, sample_valid toggling every other cycle. Required: RUN after 6 enabled samples, ~12 cycles; out_valid pulses only one cycle after each valid sample.
- Legal cfg accepted in RUN in the same cycle as sample_valid. Required: avg_enable=0 that cycle; out_valid=0 the next cycle; FLUSH entered.
- Async reset asserted mid-FILL. Required: immediate IDLE, avg_window=1, busy=0, cfg_ready=1; sample_valid is ignored until the next cfg.
